// File: rtl/opcode_phase_sequencer_if.sv
// Bus between the opcode phase sequencer and its memory/decoder neighbours.
// The sequencer takes the master modport; the surrounding logic takes the slave side.
interface opcode_phase_sequencer_if;
    logic [7:0] DataIn;
    logic       notWait;
    logic       PR_Reset_XPT;
    logic       P2_Set_CM1;
    logic       Fetch;
    logic       enable;
    logic [7:0] Source;
    logic [7:0] notSource;
    logic [4:0] XPT;
    logic [4:0] notXPT;
    logic       Prefix_CB;
    logic       Prefix_ED;
    logic       Prefix_IX;
    logic       Prefix_IY;
    logic       Fault;

    modport master (
        input  DataIn, notWait, PR_Reset_XPT, P2_Set_CM1,
        output Fetch, enable, Source, notSource, XPT, notXPT,
               Prefix_CB, Prefix_ED, Prefix_IX, Prefix_IY, Fault
    );

    modport slave (
        output DataIn, notWait, PR_Reset_XPT, P2_Set_CM1,
        input  Fetch, enable, Source, notSource, XPT, notXPT,
               Prefix_CB, Prefix_ED, Prefix_IX, Prefix_IY, Fault
    );
endinterface

// File: rtl/opcode_phase_sequencer.sv
// M1 opcode fetch, prefix collection and execution-phase timer feeding the X1 decoder.
// Every output, including the complement rails, is a flop so the rails never glitch apart.
module opcode_phase_sequencer #(
    parameter int XPT_MAX = 31
) (
    input  logic                    CLK,
    input  logic                    notReset,
    opcode_phase_sequencer_if.master bus
);
    typedef enum logic [1:0] {RST, M1_T1, M1_T2, EXEC} state_t;

    state_t     state;
    logic       fetch;
    logic       enable;
    logic [7:0] source;
    logic [7:0] not_source;
    logic [4:0] xpt;
    logic [4:0] not_xpt;
    logic       prefix_cb;
    logic       prefix_ed;
    logic       prefix_ix;
    logic       prefix_iy;
    logic       fault;

    localparam logic [4:0] XPT_LIMIT = 5'(XPT_MAX);

    always_ff @(posedge CLK) begin
        if (!notReset) begin
            state      <= RST;
            fetch      <= 1'b0;
            enable     <= 1'b0;
            source     <= 8'h00;
            not_source <= 8'hFF;
            xpt        <= 5'd0;
            not_xpt    <= 5'h1F;
            prefix_cb  <= 1'b0;
            prefix_ed  <= 1'b0;
            prefix_ix  <= 1'b0;
            prefix_iy  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                RST: begin
                    state <= M1_T1;
                    fetch <= 1'b1;
                end
                M1_T1: begin
                    state <= M1_T2;
                end
                M1_T2: begin
                    if (bus.notWait) begin
                        // Prefix bytes loop back for another fetch without touching Source
                        case (bus.DataIn)
                            8'hCB: begin
                                prefix_cb <= 1'b1;
                                state     <= M1_T1;
                            end
                            8'hED: begin
                                prefix_ed <= 1'b1;
                                state     <= M1_T1;
                            end
                            8'hDD: begin
                                prefix_ix <= 1'b1;
                                prefix_iy <= 1'b0;
                                state     <= M1_T1;
                            end
                            8'hFD: begin
                                prefix_iy <= 1'b1;
                                prefix_ix <= 1'b0;
                                state     <= M1_T1;
                            end
                            default: begin
                                source     <= bus.DataIn;
                                not_source <= ~bus.DataIn;
                                xpt        <= 5'd0;
                                not_xpt    <= 5'h1F;
                                fetch      <= 1'b0;
                                enable     <= 1'b1;
                                state      <= EXEC;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    if (bus.notWait) begin
                        if (bus.P2_Set_CM1) begin
                            state     <= M1_T1;
                            fetch     <= 1'b1;
                            enable    <= 1'b0;
                            xpt       <= 5'd0;
                            not_xpt   <= 5'h1F;
                            prefix_cb <= 1'b0;
                            prefix_ed <= 1'b0;
                            prefix_ix <= 1'b0;
                            prefix_iy <= 1'b0;
                        end else if (bus.PR_Reset_XPT) begin
                            xpt     <= 5'd0;
                            not_xpt <= 5'h1F;
                        end else if (xpt < XPT_LIMIT) begin
                            xpt     <= xpt + 5'd1;
                            not_xpt <= ~(xpt + 5'd1);
                        end else begin
                            fault <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= RST;
                    fetch  <= 1'b0;
                    enable <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Fetch     = fetch;
    assign bus.enable    = enable;
    assign bus.Source    = source;
    assign bus.notSource = not_source;
    assign bus.XPT       = xpt;
    assign bus.notXPT    = not_xpt;
    assign bus.Prefix_CB = prefix_cb;
    assign bus.Prefix_ED = prefix_ed;
    assign bus.Prefix_IX = prefix_ix;
    assign bus.Prefix_IY = prefix_iy;
    assign bus.Fault     = fault;
endmodule

// File: doc/opcode_phase_sequencer.md
# opcode_phase_sequencer

Upstream stage of the X1 opcode decoder tree. Runs the M1 opcode-fetch handshake and latches the fetched byte as `Source`. Owns the 5-bit execution-phase timer `XPT`. Drives the decoder `enable` and the dual-rail `Source`/`notSource` and `XPT`/`notXPT` buses. Consumes the decoder's `PR_Reset_XPT` and `P2_Set_CM1` to restart the phase count or end the instruction. Also collects CB/ED/DD/FD prefix bytes before handing an opcode to the decoder.

## Interface
Parameters:
- `XPT_MAX`, 31: phase value at which `XPT` saturates (≤ 31).

Ports:
- `CLK`  in  1  single clock; all state changes on the rising edge.
- `notReset`  in  1  synchronous reset, active low.
- `DataIn`  in  8  data bus; opcode byte is sampled at the end of M1_T2.
- `notWait`  in  1  memory ready, active high; 0 stalls.
- `PR_Reset_XPT`  in  1  from decoder; restart the phase count.
- `P2_Set_CM1`  in  1  from decoder; instruction done, start the next M1.
- `Fetch`  out  1  high during M1_T1/M1_T2; requests an opcode read at PC.
- `enable`  out  1  decoder enable; high only in EXEC.
- `Source`, `notSource`  out  8/8  latched opcode and its exact complement.
- `XPT`, `notXPT`  out  5/5  phase timer and its exact complement.
- `Prefix_CB`, `Prefix_ED`, `Prefix_IX`, `Prefix_IY`  out  1 each  active prefix flags.
- `Fault`  out  1  sticky; `XPT` hit `XPT_MAX` while in EXEC.

## Operation
States: RST, M1_T1, M1_T2, EXEC. All outputs are registered.

Reset behaviour:
- `notReset`=0 at an edge forces state RST.
- Reset values: `Source`=0x00, `notSource`=0xFF, `XPT`=0, `notXPT`=0x1F, `Fetch`=0, `enable`=0, all prefix flags 0, `Fault`=0.
- Reset dominates every other input, including mid-fetch and mid-EXEC.

Transitions:
- RST → M1_T1 on the first edge with `notReset`=1.
- M1_T1 → M1_T2 unconditionally.
- M1_T2 with `notWait`=0: hold in M1_T2.
- M1_T2 with `notWait`=1: sample `DataIn`, then:
  - 0xCB: set `Prefix_CB`, go to M1_T1.
  - 0xED: set `Prefix_ED`, go to M1_T1.
  - 0xDD: set `Prefix_IX`, clear `Prefix_IY`, go to M1_T1.
  - 0xFD: set `Prefix_IY`, clear `Prefix_IX`, go to M1_T1.
  - any other byte: load `Source`, set `XPT`=0, go to EXEC.
- Prefix bytes never change `Source`. Successive DD/FD: the last one wins.

EXEC behaviour. Inputs `PR_Reset_XPT` and `P2_Set_CM1` are honoured only in EXEC with `notWait`=1.
- `notWait`=0: `XPT` frozen, decoder inputs are ignored, state held.
- `P2_Set_CM1`=1: go to M1_T1, set `XPT`=0, clear all prefix flags. This takes priority over `PR_Reset_XPT`.
- `PR_Reset_XPT`=1 only: set `XPT`=0, stay in EXEC.
- Neither asserted:
  - `XPT` < `XPT_MAX`: increment `XPT`.
  - `XPT` = `XPT_MAX`: hold, set `Fault`.

Output rules:
- `Fault` clears only on reset.
- `notSource` always equals ~`Source` and `notXPT` always equals ~`XPT`, including at reset.
- `enable`=1 iff state is EXEC. `Fetch`=1 iff state is M1_T1 or M1_T2.

## Timing
- Zero-wait fetch: cycle n M1_T1, cycle n+1 M1_T2 (`DataIn` sampled at the closing edge), cycle n+2 EXEC with `XPT`=0 and the new `Source`.
- Each M1_T2 wait cycle adds one cycle of latency.
- Each prefix byte adds 2 cycles.
- `P2_Set_CM1` seen in EXEC at cycle k: `enable`=0 and M1_T1 at k+1.
  - Minimum instruction length is 3 cycles (`P2_Set_CM1` at `XPT`=0).
- `PR_Reset_XPT` at cycle k: `XPT`=0 at k+1.

## Test plan
- Reset, then fetch 0x01 with `notWait`=1:
  - `Fetch` high for 2 cycles, then `enable`=1, `Source`=0x01, `notSource`=0xFE, `XPT`=0.
  - `XPT` then counts 1, 2, 3.
  - `P2_Set_CM1` at `XPT`=3: next cycle M1_T1, `XPT`=0, `enable`=0.
- Hold `notWait`=0 for 3 cycles in M1_T2: `Fetch` stays high, `Source` unchanged; latch on release with total fetch latency 5.
- Fetch DD, CB, then 0x06:
  - `Prefix_IX`=`Prefix_CB`=1, `Source`=0x06.
  - EXEC entered 6 cycles after the first M1_T1.
  - Flags clear after `P2_Set_CM1`.
- In EXEC at `XPT`=5:
  - Assert `PR_Reset_XPT` → `XPT`=0.
  - Assert both inputs together → M1_T1 (`P2_Set_CM1` wins).
  - Hold `notWait`=0 → `XPT` frozen at its value.
- Run EXEC with no decoder inputs: `XPT` saturates at 31 and `Fault`=1; reset clears it.
- Pull `notReset` low during M1_T2 and during EXEC (`XPT`=7): all outputs take reset values at the next edge, and the sequence restarts in M1_T1.
